// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: pipeline condition codes,
// calculator operation selects and the sequencer state type.
package muldiv_sequencer_pkg;

    localparam logic [1:0] COND_FLOW  = 2'b00;
    localparam logic [1:0] COND_STALL = 2'b01;
    localparam logic [1:0] COND_ZERO  = 2'b10;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'b00,
        MDS_RUN  = 2'b01,
        MDS_DONE = 2'b10
    } mds_state_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequences the multi-cycle multiply/divide calculator: enables it, stalls the
// pipeline while it runs, pulses the HI/LO write and aborts on flush or timeout.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       flush,
    input  logic       hold,
    input  logic       calc_done,
    output logic       calc_ena,
    output logic [1:0] calc_sel,
    output logic       hilo_we,
    output logic [1:0] cond_front,
    output logic [1:0] cond_ex,
    output logic [1:0] cond_back,
    output logic       busy,
    output logic       err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mds_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          calc_ena_q, calc_ena_d;
    logic [1:0]    calc_sel_q, calc_sel_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MDS_IDLE;
            cnt_q      <= '0;
            calc_ena_q <= 1'b0;
            calc_sel_q <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            calc_ena_q <= calc_ena_d;
            calc_sel_q <= calc_sel_d;
            err_q      <= err_d;
        end
    end

    // In RUN: flush beats completion, completion beats the watchdog, and the
    // watchdog fires even while the pipeline is held.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        calc_ena_d = calc_ena_q;
        calc_sel_d = calc_sel_q;
        err_d      = 1'b0;
        case (state_q)
            MDS_IDLE: begin
                if (start && !flush && !hold) begin
                    state_d    = MDS_RUN;
                    calc_ena_d = 1'b1;
                    calc_sel_d = op;
                    cnt_d      = '0;
                end
            end
            MDS_RUN: begin
                if (flush) begin
                    state_d    = MDS_IDLE;
                    calc_ena_d = 1'b0;
                end else if (calc_done) begin
                    state_d    = MDS_DONE;
                    calc_ena_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = MDS_IDLE;
                    calc_ena_d = 1'b0;
                    err_d      = 1'b1;
                end else if (!hold) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MDS_DONE: begin
                if (!hold) begin
                    state_d = MDS_IDLE;
                end
            end
            default: begin
                state_d    = MDS_IDLE;
                calc_ena_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        cond_front = COND_FLOW;
        cond_ex    = COND_FLOW;
        cond_back  = COND_FLOW;
        if (hold) begin
            cond_front = COND_STALL;
            cond_ex    = COND_STALL;
            cond_back  = COND_STALL;
        end else if (state_q == MDS_RUN) begin
            cond_front = COND_STALL;
            cond_ex    = COND_STALL;
            cond_back  = COND_ZERO;
        end
    end

    assign hilo_we  = (state_q == MDS_DONE) && !hold;
    assign busy     = (state_q == MDS_RUN) || (state_q == MDS_DONE);
    assign calc_ena = calc_ena_q;
    assign calc_sel = calc_sel_q;
    assign err      = err_q;

endmodule
